// File: rtl/mfda_ctrl_pkg.sv
// rtl/mfda_ctrl_pkg.sv - shared state encoding and pump indices for the inlet dose sequencer
package mfda_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DOSE3   = 3'd1,
    S_DOSE2   = 3'd2,
    S_DOSE1   = 3'd3,
    S_MIX     = 3'd4,
    S_COLLECT = 3'd5
  } seq_state_t;

  localparam int PUMP_SOLN1 = 0;
  localparam int PUMP_SOLN2 = 1;
  localparam int PUMP_SOLN3 = 2;

  function automatic logic [2:0] pump_onehot(input seq_state_t s);
    logic [2:0] p;
    p = '0;
    case (s)
      S_DOSE1: p[PUMP_SOLN1] = 1'b1;
      S_DOSE2: p[PUMP_SOLN2] = 1'b1;
      S_DOSE3: p[PUMP_SOLN3] = 1'b1;
      default: p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/tick_timer.sv
// rtl/tick_timer.sv - prescaled tick counter flagging the last cycle of a phase
module tick_timer #(
  parameter int CNT_W    = 16,
  parameter int PRESCALE = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [CNT_W-1:0] load,
  output logic             expired
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] ticks_q, ticks_d;
  logic             tick;

  always_comb begin
    tick    = (presc_q == PRE_LAST);
    presc_d = tick ? '0 : presc_q + PW'(1);
    ticks_d = tick ? ticks_q + CNT_W'(1) : ticks_q;
    if (clear) begin
      presc_d = '0;
      ticks_d = '0;
    end
  end

  // Fires on the final cycle of tick load-1, so a phase of N ticks spans N*PRESCALE cycles.
  assign expired = tick && (ticks_q == load - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
      ticks_q <= '0;
    end else begin
      presc_q <= presc_d;
      ticks_q <= ticks_d;
    end
  end

endmodule

// File: rtl/inlet_dose_sequencer.sv
// rtl/inlet_dose_sequencer.sv - sequences soln3/soln2/soln1 pumps, mix wait and outlet collection
module inlet_dose_sequencer
  import mfda_ctrl_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter int PRESCALE      = 1000,
  parameter int MIX_TICKS     = 500,
  parameter int COLLECT_TICKS = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] dose1_ticks,
  input  logic [CNT_W-1:0] dose2_ticks,
  input  logic [CNT_W-1:0] dose3_ticks,
  output logic             ready,
  output logic             busy,
  output logic [2:0]       pump_en,
  output logic             out_valve,
  output logic             done,
  output logic             err
);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] dose1_q, dose2_q, dose3_q;
  logic [CNT_W-1:0] limit;
  logic             accept, timer_clear, expired;
  logic             done_d, err_d;
  logic             ready_q, busy_q, out_valve_q, done_q, err_q;
  logic [2:0]       pump_en_q;

  assign accept = (state_q == S_IDLE) && start && !abort;

  tick_timer #(.CNT_W(CNT_W), .PRESCALE(PRESCALE)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .load    (limit),
    .expired (expired)
  );

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_DOSE3:   limit = dose3_q;
      S_DOSE2:   limit = dose2_q;
      S_DOSE1:   limit = dose1_q;
      S_MIX:     limit = CNT_W'(MIX_TICKS);
      S_COLLECT: limit = CNT_W'(COLLECT_TICKS);
      default:   limit = '0;
    endcase
    // Zero-length doses are skipped within the same transition.
    case (state_q)
      S_IDLE: if (accept) begin
        if (dose3_ticks != '0)      state_d = S_DOSE3;
        else if (dose2_ticks != '0) state_d = S_DOSE2;
        else if (dose1_ticks != '0) state_d = S_DOSE1;
        else                        state_d = S_MIX;
      end
      S_DOSE3: if (expired) begin
        if (dose2_q != '0)      state_d = S_DOSE2;
        else if (dose1_q != '0) state_d = S_DOSE1;
        else                    state_d = S_MIX;
      end
      S_DOSE2: if (expired) state_d = (dose1_q != '0) ? S_DOSE1 : S_MIX;
      S_DOSE1: if (expired) state_d = S_MIX;
      S_MIX:   if (expired) state_d = S_COLLECT;
      S_COLLECT: if (expired) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && abort) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      err_d   = 1'b1;
    end
    timer_clear = (state_d != state_q) || (state_q == S_IDLE);
  end

  // Outputs decode the next state so they stay aligned with state_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      dose1_q     <= '0;
      dose2_q     <= '0;
      dose3_q     <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      pump_en_q   <= '0;
      out_valve_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      if (accept) begin
        dose1_q <= dose1_ticks;
        dose2_q <= dose2_ticks;
        dose3_q <= dose3_ticks;
      end
      ready_q     <= (state_d == S_IDLE);
      busy_q      <= (state_d != S_IDLE);
      pump_en_q   <= pump_onehot(state_d);
      out_valve_q <= (state_d == S_COLLECT);
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign ready     = ready_q;
  assign busy      = busy_q;
  assign pump_en   = pump_en_q;
  assign out_valve = out_valve_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_inlet_dose_sequencer.sv
// tb/tb_inlet_dose_sequencer.sv - directed self-checking bench for inlet_dose_sequencer
module tb_inlet_dose_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, abort;
  logic [15:0] dose1_ticks, dose2_ticks, dose3_ticks;
  logic        ready, busy, out_valve, done, err;
  logic [2:0]  pump_en;
  int          total = 0;
  int          bad = 0;
  int          ndone, nerr;

  localparam logic [7:0] IDLE_V  = 8'b000_0_0_1_0_0;
  localparam logic [7:0] ABORT_V = 8'b000_0_0_1_0_1;
  localparam logic [7:0] D3_V    = 8'b100_0_1_0_0_0;

  inlet_dose_sequencer #(
    .CNT_W(16), .PRESCALE(4), .MIX_TICKS(2), .COLLECT_TICKS(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .dose1_ticks(dose1_ticks), .dose2_ticks(dose2_ticks), .dose3_ticks(dose3_ticks),
    .ready(ready), .busy(busy), .pump_en(pump_en), .out_valve(out_valve),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // {pump_en, out_valve, busy, ready, done, err}
  function automatic logic [7:0] obs_vec();
    return {pump_en, out_valve, busy, ready, done, err};
  endfunction

  // Expected outputs on cycle i after the accept edge, PRESCALE=4, MIX=2, COLLECT=3.
  function automatic logic [7:0] exp_vec(input int i, input int d3, input int d2, input int d1);
    int t;
    t = i;
    if (t < 4 * d3) return 8'b100_0_1_0_0_0;
    t = t - 4 * d3;
    if (t < 4 * d2) return 8'b010_0_1_0_0_0;
    t = t - 4 * d2;
    if (t < 4 * d1) return 8'b001_0_1_0_0_0;
    t = t - 4 * d1;
    if (t < 8) return 8'b000_0_1_0_0_0;
    t = t - 8;
    if (t < 12) return 8'b000_1_1_0_0_0;
    t = t - 12;
    if (t == 0) return 8'b000_0_0_1_1_0;
    return IDLE_V;
  endfunction

  task automatic chk(input string tag, input int cyc, input logic [7:0] o, input logic [7:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, o, e);
    end
  endtask

  task automatic start_run(input int d3, input int d2, input int d1, input bit hold);
    @(negedge clk);
    dose3_ticks = 16'(d3);
    dose2_ticks = 16'(d2);
    dose1_ticks = 16'(d1);
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  task automatic check_timeline(input string tag, input int d3, input int d2, input int d1, input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      chk(tag, i, obs_vec(), exp_vec(i, d3, d2, d1));
    end
  endtask

  task automatic count_pulses(input int cycles);
    ndone = 0;
    nerr  = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) ndone++;
      if (err) nerr++;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    dose1_ticks = '0; dose2_ticks = '0; dose3_ticks = '0;
    repeat (2) @(negedge clk);
    chk("reset", 0, obs_vec(), IDLE_V);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 0, obs_vec(), IDLE_V);

    start_run(3, 2, 1, 1'b0);
    check_timeline("run_321", 3, 2, 1, 4 * 6 + 20 + 2);

    start_run(0, 5, 0, 1'b0);
    check_timeline("run_050", 0, 5, 0, 4 * 5 + 20 + 2);

    start_run(0, 0, 0, 1'b0);
    check_timeline("run_000", 0, 0, 0, 20 + 2);

    abort = 1'b1;
    @(negedge clk);
    chk("abort_in_idle", 0, obs_vec(), IDLE_V);
    abort = 1'b0;

    start_run(3, 2, 1, 1'b0);
    check_timeline("pre_abort", 3, 2, 1, 18);
    abort = 1'b1;
    @(negedge clk);
    chk("abort_dose2", 0, obs_vec(), ABORT_V);
    abort = 1'b0;
    @(negedge clk);
    chk("abort_err_clears", 1, obs_vec(), IDLE_V);
    count_pulses(40);
    chk("no_done_after_abort", 0, 8'(ndone), 8'd0);

    @(negedge clk);
    dose3_ticks = 16'd1; dose2_ticks = '0; dose1_ticks = '0;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    chk("abort_start_idle", 0, obs_vec(), IDLE_V);
    abort = 1'b0;
    @(negedge clk);
    check_timeline("held_start", 1, 0, 0, 25);
    @(negedge clk);
    chk("held_restart", 25, obs_vec(), D3_V);
    start = 1'b0; abort = 1'b1;
    @(negedge clk);
    chk("held_abort", 0, obs_vec(), ABORT_V);
    abort = 1'b0;

    start_run(1, 1, 1, 1'b0);
    check_timeline("pre_reset", 1, 1, 1, 23);
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_in_collect", 0, obs_vec(), IDLE_V);
    rst_n = 1'b1;
    count_pulses(40);
    chk("no_done_after_reset", 0, 8'(ndone), 8'd0);
    chk("no_err_after_reset", 0, 8'(nerr), 8'd0);
    chk("idle_end", 0, obs_vec(), IDLE_V);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
